// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: frame data from the counter and the multiplexed
// display lines.
//   digits     : eight BCD digits; digit i is digits[4i+3:4i], digit 0 is rightmost
//   dig_en     : per-digit enable
//   dp         : per-digit decimal point
//   blink      : per-digit blink enable
//   lzb        : leading-zero blanking enable
//   cat        : digit select, active-low, at most one bit low
//   DISP       : segments, active-high; bit0..6 = a..g, bit7 = dp
//   frame_tick : one-cycle pulse in the first cycle of every frame
interface seg_scan_driver_if;
  logic [31:0] digits;
  logic [7:0]  dig_en;
  logic [7:0]  dp;
  logic [7:0]  blink;
  logic        lzb;
  logic [7:0]  cat;
  logic [7:0]  DISP;
  logic        frame_tick;

  modport master (
    output digits, dig_en, dp, blink, lzb,
    input  cat, DISP, frame_tick
  );

  modport slave (
    input  digits, dig_en, dp, blink, lzb,
    output cat, DISP, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes eight BCD digits onto a shared
// 8-segment bus, one digit slot of SCAN_DIV cycles at a time, eight slots
// per frame. A complete frame of inputs is latched at each frame start so
// the display never tears. Adds leading-zero blanking and blink.
//   clk  : system clock (1 kHz)
//   nrst : asynchronous active-low reset
//   bus  : seg_scan_driver_if.slave (digit data in, cat/DISP/frame_tick out)
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV   = 1,
  parameter int unsigned BLINK_HALF = 250
) (
  input  logic               clk,
  input  logic               nrst,
  seg_scan_driver_if.slave   bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  typedef enum logic {
    ST_IDLE,  // out of reset, next edge starts frame slot 0
    ST_SCAN
  } state_t;

  state_t            state, state_d;
  logic [2:0]        slot, slot_d;
  logic [DIV_W-1:0]  div, div_d;
  logic [BLK_W-1:0]  blk_cnt, blk_cnt_d;
  logic              blk_phase, blk_phase_d;

  logic [31:0]       snap_digits, snap_digits_d;
  logic [7:0]        snap_en, snap_en_d;
  logic [7:0]        snap_dp, snap_dp_d;
  logic [7:0]        snap_blink, snap_blink_d;
  logic              snap_lzb, snap_lzb_d;
  logic              snap_phase, snap_phase_d;

  logic [7:0]        cat_q, cat_d;
  logic [7:0]        disp_q, disp_d;
  logic              tick_q, tick_d;

  // Working signals of the combinational block
  logic              frame_start, slot_adv;
  logic [2:0]        next_slot;
  logic [31:0]       src_digits;
  logic [7:0]        src_en, src_dp, src_blink;
  logic              src_lzb, src_phase;
  logic [7:0]        lead;
  logic              above;
  logic [3:0]        cur;
  logic              blanked;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      4'hA:    seg7 = 7'h40;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      slot        <= '0;
      div         <= '0;
      blk_cnt     <= '0;
      blk_phase   <= 1'b1;
      snap_digits <= '0;
      snap_en     <= '0;
      snap_dp     <= '0;
      snap_blink  <= '0;
      snap_lzb    <= 1'b0;
      snap_phase  <= 1'b0;
      cat_q       <= '1;
      disp_q      <= '0;
      tick_q      <= 1'b0;
    end else begin
      state       <= state_d;
      slot        <= slot_d;
      div         <= div_d;
      blk_cnt     <= blk_cnt_d;
      blk_phase   <= blk_phase_d;
      snap_digits <= snap_digits_d;
      snap_en     <= snap_en_d;
      snap_dp     <= snap_dp_d;
      snap_blink  <= snap_blink_d;
      snap_lzb    <= snap_lzb_d;
      snap_phase  <= snap_phase_d;
      cat_q       <= cat_d;
      disp_q      <= disp_d;
      tick_q      <= tick_d;
    end
  end

  always_comb begin
    state_d       = state;
    slot_d        = slot;
    div_d         = div;
    blk_cnt_d     = blk_cnt;
    blk_phase_d   = blk_phase;
    snap_digits_d = snap_digits;
    snap_en_d     = snap_en;
    snap_dp_d     = snap_dp;
    snap_blink_d  = snap_blink;
    snap_lzb_d    = snap_lzb;
    snap_phase_d  = snap_phase;
    cat_d         = cat_q;
    disp_d        = disp_q;
    tick_d        = 1'b0;
    lead          = '0;
    above         = 1'b0;

    // Free-running blink timebase
    if (blk_cnt == BLK_LAST) begin
      blk_cnt_d   = '0;
      blk_phase_d = ~blk_phase;
    end else begin
      blk_cnt_d   = blk_cnt + BLK_W'(1);
    end

    frame_start = (state == ST_IDLE) || ((div == DIV_LAST) && (slot == 3'd7));
    slot_adv    = (state == ST_IDLE) || (div == DIV_LAST);
    next_slot   = (state == ST_IDLE) ? 3'd0 : slot + 3'd1;

    // Slot 0 outputs register on the same edge that takes the snapshot, so
    // they are decoded straight from the live inputs at frame start.
    src_digits = frame_start ? bus.digits : snap_digits;
    src_en     = frame_start ? bus.dig_en : snap_en;
    src_dp     = frame_start ? bus.dp     : snap_dp;
    src_blink  = frame_start ? bus.blink  : snap_blink;
    src_lzb    = frame_start ? bus.lzb    : snap_lzb;
    src_phase  = frame_start ? blk_phase  : snap_phase;

    // Leading-zero chain from digit 7 down; a disabled digit keeps the chain
    // alive, digit 0 never joins it.
    above = src_lzb;
    for (int unsigned k = 7; k >= 1; k--) begin
      lead[k] = above && (!src_en[k] ||
                ((src_digits[4*k +: 4] == 4'd0) && !src_dp[k]));
      above   = lead[k];
    end

    cur     = src_digits[{next_slot, 2'b00} +: 4];
    blanked = !src_en[next_slot] ||
              (src_blink[next_slot] && !src_phase) ||
              lead[next_slot];

    if (slot_adv) begin
      state_d = ST_SCAN;
      slot_d  = next_slot;
      div_d   = '0;
      cat_d   = blanked ? 8'hFF : ~(8'b1 << next_slot);
      disp_d  = blanked ? 8'h00 : {src_dp[next_slot], seg7(cur)};
      if (frame_start) begin
        tick_d        = 1'b1;
        snap_digits_d = src_digits;
        snap_en_d     = src_en;
        snap_dp_d     = src_dp;
        snap_blink_d  = src_blink;
        snap_lzb_d    = src_lzb;
        snap_phase_d  = src_phase;
      end
    end else begin
      div_d = div + DIV_W'(1);
    end
  end

  assign bus.cat        = cat_q;
  assign bus.DISP       = disp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] digits;
  logic [7:0]  dig_en, dp, blink;
  logic        lzb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_driver_if ifa ();
  seg_scan_driver_if ifb ();

  assign ifa.digits = digits;
  assign ifa.dig_en = dig_en;
  assign ifa.dp     = dp;
  assign ifa.blink  = blink;
  assign ifa.lzb    = lzb;
  assign ifb.digits = digits;
  assign ifb.dig_en = dig_en;
  assign ifb.dp     = dp;
  assign ifb.blink  = blink;
  assign ifb.lzb    = lzb;

  seg_scan_driver #(.SCAN_DIV(1), .BLINK_HALF(16)) dut_a (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifa.slave)
  );

  seg_scan_driver #(.SCAN_DIV(3), .BLINK_HALF(250)) dut_b (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifb.slave)
  );

  // Segment codes for values 0..9
  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cat_of(input int s);
    logic [7:0] c;
    c = ~(8'd1 << s);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the first cycle of a frame (bounded)
  task automatic wait_frame(input string tag);
    int unsigned n = 0;
    do begin
      step();
      n++;
    end while (!ifa.frame_tick && n < 40);
    check({tag, "_tick"}, ifa.frame_tick, 1);
  endtask

  // Check one full frame of dut_a; shown[s]=0 means slot s is blanked
  task automatic run_frame(input string tag, input logic [7:0] shown, input logic [63:0] disp);
    logic [7:0] ec;
    wait_frame(tag);
    for (int s = 0; s < 8; s++) begin
      if (s > 0) step();
      ec = shown[s] ? cat_of(s) : 8'hFF;
      check($sformatf("%s_cat%0d", tag, s), ifa.cat, ec);
      check($sformatf("%s_disp%0d", tag, s), ifa.DISP, disp[s*8 +: 8]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst   = 1'b0;
    digits = 32'h76543210;
    dig_en = 8'hFF;
    dp     = 8'h00;
    blink  = 8'h00;
    lzb    = 1'b0;

    // Reset state
    #23;
    check("rst_cat_a",  ifa.cat, 8'hFF);
    check("rst_disp_a", ifa.DISP, 8'h00);
    check("rst_tick_a", ifa.frame_tick, 1'b0);
    check("rst_cat_b",  ifb.cat, 8'hFF);

    // Full scan, SCAN_DIV=1 (dut_a) and SCAN_DIV=3 (dut_b) side by side
    @(negedge clk);
    nrst = 1'b1;
    for (int j = 0; j < 48; j++) begin
      int sa, sb;
      step();
      sa = j % 8;
      sb = (j / 3) % 8;
      check($sformatf("scan_a_cat_j%0d", j),  ifa.cat, cat_of(sa));
      check($sformatf("scan_a_disp_j%0d", j), ifa.DISP, seg_tab[sa]);
      check($sformatf("scan_a_tick_j%0d", j), ifa.frame_tick, (j % 8) == 0);
      check($sformatf("scan_b_cat_j%0d", j),  ifb.cat, cat_of(sb));
      check($sformatf("scan_b_disp_j%0d", j), ifb.DISP, seg_tab[sb]);
      check($sformatf("scan_b_tick_j%0d", j), ifb.frame_tick, (j % 24) == 0);
    end

    // Leading-zero blanking
    lzb = 1'b1; digits = 32'h00000120;
    run_frame("lz_120", 8'h07, 64'h0000_0000_0006_5B3F);
    digits = 32'h00000000;
    run_frame("lz_zero", 8'h01, 64'h0000_0000_0000_003F);
    dp = 8'h04;
    run_frame("lz_dp", 8'h07, 64'h0000_0000_00BF_3F3F);
    // F is selected but dark, A is a dash
    dp = 8'h00; digits = 32'h000000FA;
    run_frame("lz_fa", 8'h03, 64'h0000_0000_0000_0040);
    // Disabled top digit still lets the zero chain continue
    dig_en = 8'h7F; digits = 32'h50000003;
    run_frame("lz_dis", 8'h01, 64'h0000_0000_0000_004F);

    // Enables and decimal point without blanking
    lzb = 1'b0; dig_en = 8'hF0; dp = 8'h80; digits = 32'h76543210;
    run_frame("en_dp", 8'hF0, 64'h877D_6D66_0000_0000);

    // Anti-tear: mid-frame change is held off until the next frame
    dig_en = 8'hFF; dp = 8'h00; digits = 32'h11111111;
    wait_frame("tear");
    for (int s = 0; s < 8; s++) begin
      if (s > 0) step();
      check($sformatf("tear_cat%0d", s),  ifa.cat, cat_of(s));
      check($sformatf("tear_disp%0d", s), ifa.DISP, 8'h06);
      if (s == 4) digits = 32'h22222222;
    end
    run_frame("tear_next", 8'hFF, {8{8'h5B}});

    // Blink: restart so frame and blink timing are aligned to reset
    nrst = 1'b0;
    digits = 32'h11111118;
    blink  = 8'h01;
    @(negedge clk);
    nrst = 1'b1;
    for (int f = 0; f < 6; f++) begin
      if (((f / 2) % 2) == 0)
        run_frame($sformatf("blink_on_f%0d", f), 8'hFF, {{7{8'h06}}, 8'h7F});
      else
        run_frame($sformatf("blink_off_f%0d", f), 8'hFE, {{7{8'h06}}, 8'h00});
    end

    // Reset mid-frame
    blink = 8'h00; digits = 32'h76543210;
    wait_frame("midrst");
    for (int s = 0; s < 5; s++) step();
    check("midrst_pre_cat", ifa.cat, 8'hDF);
    #2;
    nrst = 1'b0;
    #1;
    check("midrst_cat",  ifa.cat, 8'hFF);
    check("midrst_disp", ifa.DISP, 8'h00);
    check("midrst_tick", ifa.frame_tick, 1'b0);
    step();
    check("midrst_hold_cat", ifa.cat, 8'hFF);
    @(negedge clk);
    nrst = 1'b1;
    step();
    check("restart_cat",  ifa.cat, 8'hFE);
    check("restart_disp", ifa.DISP, 8'h3F);
    check("restart_tick", ifa.frame_tick, 1'b1);
    step();
    check("restart_cat1",  ifa.cat, 8'hFD);
    check("restart_tick1", ifa.frame_tick, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
